// File: rtl/rssb_pkg.sv
// Shared types and constants for the rssb program loader.
package rssb_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_DATA,
    LD_CSUM,
    LD_RUN,
    LD_ERR
  } ld_state_t;

  // A frame length is usable when it is non-zero and fits in the memory.
  function automatic logic len_ok(input int len, input int depth);
    return (len != 0) && (len <= depth);
  endfunction

endpackage

// File: rtl/rssb_loader_if.sv
// Byte-stream handshake between the host and the rssb loader.
interface rssb_loader_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  // A byte moves on a rising edge where in_valid and in_ready are both high;
  // in_ready may depend combinationally on the loader's reload input.
  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/rssb_loader_csum.sv
// Modular accumulator for the frame checksum; clear has priority over add.
module rssb_loader_csum
  import rssb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sum_o
);

  logic [WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/rssb_loader.sv
// Loads a LEN/data/CSUM framed stream into rssb memory and holds the core in
// reset until the checksum of the loaded words verifies.
module rssb_loader
  import rssb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MEM_DEPTH = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst,
  rssb_loader_if.slave     strm,
  input  logic             reload,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             core_rst,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] nwords,
  output ld_state_t        state_o
);

  localparam logic [WIDTH-1:0] BASE_W = WIDTH'(BASE_ADDR);

  ld_state_t        state_q, state_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             core_rst_q, core_rst_d;
  logic             csum_clr, csum_add;
  logic [WIDTH-1:0] sum;
  logic             xfer;

  assign strm.in_ready = ((state_q == LD_IDLE) || (state_q == LD_DATA) ||
                          (state_q == LD_CSUM)) && !reload;
  assign xfer = strm.in_valid && strm.in_ready;

  rssb_loader_csum #(.WIDTH(WIDTH)) u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (csum_clr),
    .add_i  (csum_add),
    .data_i (strm.in_data),
    .sum_o  (sum)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    csum_clr = 1'b0;
    csum_add = 1'b0;

    case (state_q)
      LD_IDLE: begin
        if (xfer) begin
          len_d = strm.in_data;
          if (len_ok(int'(strm.in_data), MEM_DEPTH)) begin
            cnt_d    = '0;
            csum_clr = 1'b1;
            state_d  = LD_DATA;
          end else begin
            state_d = LD_ERR;
          end
        end
      end
      LD_DATA: begin
        if (xfer) begin
          we_d     = 1'b1;
          addr_d   = BASE_W + cnt_q;
          wdata_d  = strm.in_data;
          cnt_d    = cnt_q + 1'b1;
          csum_add = 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = LD_CSUM;
          end
        end
      end
      LD_CSUM: begin
        if (xfer) begin
          state_d = (strm.in_data == sum) ? LD_RUN : LD_ERR;
        end
      end
      default: ;
    endcase

    // Reload overrides everything; in_ready is already low so no byte moves.
    if (reload) begin
      state_d  = LD_IDLE;
      cnt_d    = '0;
      csum_clr = 1'b1;
    end

    core_rst_d = (state_d != LD_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= LD_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_rst  = core_rst_q;
  assign done      = (state_q == LD_RUN);
  assign err       = (state_q == LD_ERR);
  assign nwords    = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_rssb_loader.sv
// Bench for rssb_loader: a default instance and a small, offset instance share
// one stimulus stream; each is checked against a frame-level model every cycle.
module tb_rssb_loader;
  import rssb_pkg::*;

  localparam int W      = 8;
  localparam int DEPTH1 = 4;
  localparam int BASE1  = 254;

  // ---------------- clock / reset / stimulus signals ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         reload = 1'b0;
  logic         v = 1'b0;
  logic [W-1:0] d = '0;

  always #5 clk = ~clk;

  rssb_loader_if #(.WIDTH(W)) if0 ();
  rssb_loader_if #(.WIDTH(W)) if1 ();

  assign if0.in_valid = v;
  assign if0.in_data  = d;
  assign if1.in_valid = v;
  assign if1.in_data  = d;

  logic [1:0]        rdy_w, we_w, crst_w, done_w, err_w;
  logic [1:0][W-1:0] addr_w, wd_w, nw_w;
  ld_state_t         st0, st1;

  assign rdy_w = {if1.in_ready, if0.in_ready};

  rssb_loader #(.WIDTH(W)) dut0 (
    .clk(clk), .rst(rst), .strm(if0.slave), .reload(reload),
    .mem_we(we_w[0]), .mem_addr(addr_w[0]), .mem_wdata(wd_w[0]),
    .core_rst(crst_w[0]), .done(done_w[0]), .err(err_w[0]),
    .nwords(nw_w[0]), .state_o(st0)
  );

  rssb_loader #(.WIDTH(W), .MEM_DEPTH(DEPTH1), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst(rst), .strm(if1.slave), .reload(reload),
    .mem_we(we_w[1]), .mem_addr(addr_w[1]), .mem_wdata(wd_w[1]),
    .core_rst(crst_w[1]), .done(done_w[1]), .err(err_w[1]),
    .nwords(nw_w[1]), .state_o(st1)
  );

  // ---------------- reference model (frame level) ----------------
  // status: 0 = loading, 1 = running, 2 = rejected
  int           m_status[2];
  int           m_len[2];     // -1 while waiting for the LEN word
  int           m_cnt[2];
  int           m_total[2];   // unbounded sum of data words
  logic         m_we[2];
  logic [W-1:0] m_addr[2];
  logic [W-1:0] m_wd[2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 256 : DEPTH1;
  endfunction

  function automatic int base_of(input int k);
    return (k == 0) ? 0 : BASE1;
  endfunction

  task automatic model_step(input int k, input logic vv, input logic [W-1:0] dd,
                            input logic rl, input logic rn);
    if (!rn) begin
      m_status[k] = 0; m_len[k] = -1; m_cnt[k] = 0; m_total[k] = 0;
      m_we[k] = 1'b0; m_addr[k] = '0; m_wd[k] = '0;
      return;
    end
    m_we[k] = 1'b0;
    if (rl) begin
      m_status[k] = 0; m_len[k] = -1; m_cnt[k] = 0; m_total[k] = 0;
      return;
    end
    if (m_status[k] == 0 && vv) begin
      if (m_len[k] < 0) begin
        if (int'(dd) == 0 || int'(dd) > depth_of(k)) m_status[k] = 2;
        else begin
          m_len[k] = int'(dd); m_cnt[k] = 0; m_total[k] = 0;
        end
      end else if (m_cnt[k] < m_len[k]) begin
        m_we[k]   = 1'b1;
        m_addr[k] = W'((base_of(k) + m_cnt[k]) % 256);
        m_wd[k]   = dd;
        m_cnt[k]++;
        m_total[k] += int'(dd);
      end else begin
        m_status[k] = (int'(dd) == m_total[k] % 256) ? 1 : 2;
      end
    end
  endtask

  // ---------------- scoreboard / checking ----------------
  int           total = 0;
  int           bad = 0;
  logic         primed = 1'b0;
  logic         sb_on = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic vv, input logic [W-1:0] dd, input logic rl,
                      input logic rn);
    @(negedge clk);
    v = vv; d = dd; reload = rl; rst = rn;
    #1;
    if (primed) begin
      for (int k = 0; k < 2; k++)
        check("in_ready", k, 32'(rdy_w[k]), 32'(m_status[k] == 0 && !rl));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, vv, dd, rl, rn);
    primed = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("mem_we", k, 32'(we_w[k]), 32'(m_we[k]));
      check("mem_addr", k, 32'(addr_w[k]), 32'(m_addr[k]));
      check("mem_wdata", k, 32'(wd_w[k]), 32'(m_wd[k]));
      check("done", k, 32'(done_w[k]), 32'(m_status[k] == 1));
      check("err", k, 32'(err_w[k]), 32'(m_status[k] == 2));
      check("core_rst", k, 32'(crst_w[k]), 32'(m_status[k] != 1));
      check("nwords", k, 32'(nw_w[k]), 32'(m_cnt[k]));
    end
    if (sb_on && we_w[1]) begin
      if (exp_q.size() == 0) check("sb_extra_write", 1, 32'(we_w[1]), 32'(0));
      else check("sb_wrap_addr", 1, 32'(addr_w[1]), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic send_frame(input logic [W-1:0] bytes[$]);
    foreach (bytes[i]) step(1'b1, bytes[i], 1'b0, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         rl;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wd;
    logic         done;
    logic         err;
    logic         crst;
    logic [W-1:0] nw;
  } vec_t;

  vec_t tbl[14];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [W-1:0] fr[$];
    logic [W-1:0] csum;
    int           len;
    logic         vv, rl, rn;

    // nominal, reload from RUN, bad checksum, ignored byte in ERR, zero length
    tbl[0]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[1]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[2]  = '{1'b1, 8'h0A, 1'b0, 1'b1, 8'h01, 8'h0A, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[3]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[4]  = '{1'b1, 8'h0E, 1'b0, 1'b0, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd3};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[6]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h01, 8'h22, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 8'h22, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[10] = '{1'b1, 8'h55, 1'b0, 1'b0, 8'h01, 8'h22, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h22, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[12] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h01, 8'h22, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h22, 1'b0, 1'b0, 1'b1, 8'd0};

    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("reset_state", 0, 32'(st0), 32'(LD_IDLE));

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].rl, 1'b1);
      check("tbl_we", i, 32'(we_w[0]), 32'(tbl[i].we));
      check("tbl_addr", i, 32'(addr_w[0]), 32'(tbl[i].addr));
      check("tbl_wdata", i, 32'(wd_w[0]), 32'(tbl[i].wd));
      check("tbl_done", i, 32'(done_w[0]), 32'(tbl[i].done));
      check("tbl_err", i, 32'(err_w[0]), 32'(tbl[i].err));
      check("tbl_core_rst", i, 32'(crst_w[0]), 32'(tbl[i].crst));
      check("tbl_nwords", i, 32'(nw_w[0]), 32'(tbl[i].nw));
    end

    // oversize length on the 4-word instance
    step(1'b1, 8'h05, 1'b0, 1'b1);
    check("len5_err", 1, 32'(err_w[1]), 32'(1));
    check("len5_no_we", 1, 32'(we_w[1]), 32'(0));
    step(1'b0, '0, 1'b1, 1'b1);

    // wrap with stalls on the offset instance
    exp_q = '{8'hFE, 8'hFF, 8'h00};
    sb_on = 1'b1;
    fr = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
    foreach (fr[i]) begin
      step(1'b1, fr[i], 1'b0, 1'b1);
      repeat ($urandom_range(1, 3)) step(1'b0, 8'hAA, 1'b0, 1'b1);
    end
    sb_on = 1'b0;
    check("wrap_all_written", 1, 32'(exp_q.size()), 32'(0));
    check("wrap_run", 1, 32'(done_w[1]), 32'(1));
    step(1'b0, '0, 1'b1, 1'b1);

    // reload mid-frame with a byte presented in the same cycle
    send_frame('{8'h04, 8'h11, 8'h22});
    step(1'b1, 8'h33, 1'b1, 1'b1);
    check("reload_idle", 0, 32'(st0), 32'(LD_IDLE));
    check("reload_nwords", 0, 32'(nw_w[0]), 32'(0));
    send_frame('{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A});
    check("reload_reload_done", 0, 32'(done_w[0]), 32'(1));
    check("reload_reload_done", 1, 32'(done_w[1]), 32'(1));
    step(1'b0, '0, 1'b1, 1'b1);

    // reset mid-frame
    send_frame('{8'h04, 8'h11, 8'h22});
    step(1'b1, 8'h33, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("rst_we", k, 32'(we_w[k]), 32'(0));
      check("rst_addr", k, 32'(addr_w[k]), 32'(0));
      check("rst_wdata", k, 32'(wd_w[k]), 32'(0));
      check("rst_nwords", k, 32'(nw_w[k]), 32'(0));
      check("rst_core_rst", k, 32'(crst_w[k]), 32'(1));
    end
    check("rst_state", 1, 32'(st1), 32'(LD_IDLE));
    send_frame('{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A});
    check("rst_reload_done", 0, 32'(done_w[0]), 32'(1));
    check("rst_reload_nwords", 1, 32'(nw_w[1]), 32'(4));

    // reload from RUN
    step(1'b0, '0, 1'b1, 1'b1);
    check("run_reload_core_rst", 0, 32'(crst_w[0]), 32'(1));
    check("run_reload_done", 0, 32'(done_w[0]), 32'(0));
    step(1'b0, '0, 1'b0, 1'b1);
    check("idle_ready", 0, 32'(rdy_w[0]), 32'(1));

    // randomized frames, stalls, reloads and resets
    fr = {};
    for (int c = 0; c < 3000; c++) begin
      if (fr.size() == 0 || m_status[0] != 0) begin
        step(1'b0, '0, 1'b1, 1'b1);
        fr = {};
        len = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
        fr.push_back(W'(len));
        csum = '0;
        for (int i = 0; i < len; i++) begin
          fr.push_back(W'($urandom_range(0, 255)));
          csum = csum + fr[fr.size() - 1];
        end
        fr.push_back(($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : csum);
        continue;
      end
      vv = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 59) == 0);
      rn = ($urandom_range(0, 199) != 0);
      step(vv, fr[0], rl, rn);
      if (!rn || rl) fr = {};
      else if (vv) void'(fr.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rssb_loader.md
Name: rssb_loader

Overview:
- Program loader directly upstream of the rssb core.
- Accepts a framed byte stream over a valid/ready handshake and writes it into the core's program/data memory through a write port.
- Holds the core in reset while loading; releases it only after the frame checksum verifies.
- Sits between the host/bench stimulus and the rssb memory and reset inputs.

Parameters:
- WIDTH, 8, data/address width; matches the rssb WIDTH.
- MEM_DEPTH, 256, number of writable memory words; must be ≤ 2**WIDTH.
- BASE_ADDR, 0, address of the first loaded word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset: rst=0 at a rising edge resets the block.
- in_valid  in  1  stream byte valid.
- in_data  in  WIDTH  stream byte.
- in_ready  out  1  loader can accept a byte.
- reload  in  1  single-cycle request to abort or restart and return to IDLE.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  WIDTH  memory write address.
- mem_wdata  out  WIDTH  memory write data.
- core_rst  out  1  active-high reset to the rssb core.
- done  out  1  load verified; core running.
- err  out  1  frame rejected.
- nwords  out  WIDTH  words written in the current or last frame.

Behaviour:
- Frame format: LEN word (L), then L data words, then a CSUM word. CSUM equals the sum of the data words mod 2**WIDTH.
- Transfer occurs when in_valid && in_ready at a rising edge.
- in_ready = (state in {IDLE, DATA, CSUM}) && !reload. This is combinational on reload only.
- States:
  - IDLE
  - DATA
  - CSUM
  - RUN
  - ERR
- IDLE:
  - Accepting a word latches L.
  - L==0 or L>MEM_DEPTH: go to ERR.
  - Otherwise: clear the word counter and sum, then go to DATA.
- DATA:
  - Each transfer writes the word and adds it to the sum.
  - After the L-th transfer, go to CSUM.
  - Back-to-back transfers every cycle are supported.
- CSUM:
  - Transfer word == sum: go to RUN.
  - Otherwise: go to ERR.
- RUN: core_rst=0, done=1; remain there until reload.
- ERR: err=1, core_rst=1; remain there until reload.
- reload in any state: next state is IDLE; counter and sum are cleared; done and err drop. A byte presented in the same cycle is not accepted.
- Write timing: mem_we, mem_addr and mem_wdata are registered.
  - A data transfer at edge k drives mem_we=1 with that address and data during the cycle after edge k.
  - mem_we=0 otherwise; mem_addr and mem_wdata hold their last values.
- Address: BASE_ADDR + i, for word index i = 0..L-1, truncated to WIDTH bits. This wraps past 2**WIDTH-1 to 0.
- nwords increments on each data transfer and holds its value in RUN and ERR.
- core_rst is registered:
  - It is 1 in every state except RUN.
  - It falls the cycle after the CSUM match edge.
  - It rises the cycle after reload is seen in RUN.
- Reset (rst=0 at an edge) works from any state, including mid-frame:
  - state=IDLE, core_rst=1.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - done=0, err=0, nwords=0.
  - Internal sum=0 and L=0.
  - Memory contents are not cleared.
- Sum arithmetic: WIDTH-bit modular addition; carries are discarded.

Decomposition:
- Package rssb_pkg:
  - ld_state_t enum {LD_IDLE, LD_DATA, LD_CSUM, LD_RUN, LD_ERR}.
  - Default WIDTH constant.
- One sub-module, rssb_loader_csum: WIDTH-bit accumulator with clear and add-enable inputs and a sum output. It is instantiated once.
- The FSM, counter and write-port registers live in rssb_loader.

Test Plan:
- Nominal load: stream 03,05,0A,FF,0E back-to-back.
  - Expect writes (00,05), (01,0A), (02,FF) on consecutive cycles.
  - Expect core_rst=0 and done=1 one cycle after the 0E transfer; nwords=3.
- Bad checksum: stream 02,11,22,00.
  - Expect writes at 00 and 01, then err=1.
  - core_rst stays 1, in_ready=0, done=0.
- Zero/oversize length:
  - Stream LEN=00: expect ERR with no mem_we.
  - With MEM_DEPTH=4, stream LEN=05: expect ERR with no mem_we.
- Wrap and stalls: BASE_ADDR=FE, stream 03,01,02,03,06 with in_valid gaps of 1–3 cycles.
  - Expect writes to FE, FF, 00, then RUN.
- Reload/reset mid-frame:
  - After 2 of 4 data words, pulse reload together with in_valid.
  - Expect that byte is not accepted and the block returns to IDLE; a new full frame then loads correctly.
  - Repeat the same check with rst=0 mid-frame, and verify all outputs take their reset values.
- Reload from RUN: after a good load, pulse reload.
  - Expect core_rst=1 the next cycle, done=0, and in_ready=1 in IDLE.
